// File: rtl/mxv_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module  : mxv_sequencer_pkg
// Brief   : Shared word type, frame delimiters and sequencer state encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mxv_sequencer_pkg;

  typedef logic [15:0] word_lenght_t;

  localparam word_lenght_t SOF_WORD = 16'h00FE;
  localparam word_lenght_t EOF_WORD = 16'h00EF;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_GET_N     = 4'd1,
    ST_LOAD_M    = 4'd2,
    ST_LOAD_V    = 4'd3,
    ST_WAIT_END  = 4'd4,
    ST_RUN       = 4'd5,
    ST_WAIT_DONE = 4'd6,
    ST_READ      = 4'd7,
    ST_SEND      = 4'd8,
    ST_WAIT_TX   = 4'd9
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/mxv_sequencer_timeout.sv
//------------------------------------------------------------------------------
// Module  : mxv_seq_timeout
// Brief   : Loadable down-counter; flags expiry when it runs out while enabled.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mxv_seq_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_count <= CNT_W'(TIMEOUT);
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // A word arriving in the expiry cycle takes priority over the timeout.
  assign expired = enable && !load && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mxv_sequencer.sv
//------------------------------------------------------------------------------
// Module  : mxv_sequencer
// Brief   : Frame parser / MxV loader / result streamer between UART and MxV.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mxv_sequencer
  import mxv_sequencer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MAX_N   = 8,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              ld_we,
  output logic              ld_sel,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic [3:0]        mxv_n,
  output logic              mxv_start,
  input  logic              mxv_done,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_enable,
  input  logic              tx_busy,
  output logic              busy,
  output logic              frame_err
);

  seq_state_t        r_state, w_state_nxt;
  logic [3:0]        r_row, w_row_nxt;
  logic [3:0]        r_col, w_col_nxt;
  logic [3:0]        r_k, w_k_nxt;
  logic [3:0]        r_mxv_n, w_mxv_n_nxt;
  logic              r_ld_we, w_ld_we_nxt;
  logic              r_ld_sel, w_ld_sel_nxt;
  logic [ADDR_W-1:0] r_ld_addr, w_ld_addr_nxt;
  logic [DATA_W-1:0] r_ld_data, w_ld_data_nxt;
  logic              r_mxv_start, w_mxv_start_nxt;
  logic [DATA_W-1:0] r_tx_data, w_tx_data_nxt;
  logic              r_tx_enable, w_tx_enable_nxt;
  logic              r_frame_err, w_frame_err_nxt;
  logic              r_seen_busy, w_seen_busy_nxt;
  logic              w_in_frame, w_expired, w_n_ok;
  logic [ADDR_W-1:0] w_m_addr;

  assign w_in_frame = r_state inside {ST_GET_N, ST_LOAD_M, ST_LOAD_V, ST_WAIT_END};
  assign w_n_ok     = (rx_data != '0) && (rx_data <= DATA_W'(MAX_N));
  assign w_m_addr   = ADDR_W'(r_row) * ADDR_W'(r_mxv_n) + ADDR_W'(r_col);

  mxv_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (rx_valid || !w_in_frame),
    .enable  (w_in_frame),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_k         <= '0;
      r_mxv_n     <= '0;
      r_ld_we     <= 1'b0;
      r_ld_sel    <= 1'b0;
      r_ld_addr   <= '0;
      r_ld_data   <= '0;
      r_mxv_start <= 1'b0;
      r_tx_data   <= '0;
      r_tx_enable <= 1'b0;
      r_frame_err <= 1'b0;
      r_seen_busy <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_k         <= w_k_nxt;
      r_mxv_n     <= w_mxv_n_nxt;
      r_ld_we     <= w_ld_we_nxt;
      r_ld_sel    <= w_ld_sel_nxt;
      r_ld_addr   <= w_ld_addr_nxt;
      r_ld_data   <= w_ld_data_nxt;
      r_mxv_start <= w_mxv_start_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_enable <= w_tx_enable_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_seen_busy <= w_seen_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_row_nxt       = r_row;
    w_col_nxt       = r_col;
    w_k_nxt         = r_k;
    w_mxv_n_nxt     = r_mxv_n;
    w_ld_we_nxt     = 1'b0;
    w_ld_sel_nxt    = r_ld_sel;
    w_ld_addr_nxt   = r_ld_addr;
    w_ld_data_nxt   = r_ld_data;
    w_mxv_start_nxt = 1'b0;
    w_tx_data_nxt   = r_tx_data;
    w_tx_enable_nxt = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_seen_busy_nxt = r_seen_busy;

    case (r_state)
      ST_IDLE: begin
        if (rx_valid && (rx_data == DATA_W'(SOF_WORD))) w_state_nxt = ST_GET_N;
      end
      ST_GET_N: begin
        if (rx_valid) begin
          if (w_n_ok) begin
            w_mxv_n_nxt = rx_data[3:0];
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_state_nxt = ST_LOAD_M;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end
      end
      ST_LOAD_M: begin
        if (rx_valid) begin
          w_ld_we_nxt   = 1'b1;
          w_ld_sel_nxt  = 1'b0;
          w_ld_addr_nxt = w_m_addr;
          w_ld_data_nxt = rx_data;
          if (r_col == r_mxv_n - 4'd1) begin
            w_col_nxt = '0;
            if (r_row == r_mxv_n - 4'd1) begin
              w_row_nxt   = '0;
              w_state_nxt = ST_LOAD_V;
            end else begin
              w_row_nxt = r_row + 4'd1;
            end
          end else begin
            w_col_nxt = r_col + 4'd1;
          end
        end
      end
      ST_LOAD_V: begin
        if (rx_valid) begin
          w_ld_we_nxt   = 1'b1;
          w_ld_sel_nxt  = 1'b1;
          w_ld_addr_nxt = ADDR_W'(r_col);
          w_ld_data_nxt = rx_data;
          if (r_col == r_mxv_n - 4'd1) begin
            w_col_nxt   = '0;
            w_state_nxt = ST_WAIT_END;
          end else begin
            w_col_nxt = r_col + 4'd1;
          end
        end
      end
      ST_WAIT_END: begin
        if (rx_valid) begin
          if (rx_data == DATA_W'(EOF_WORD)) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        w_mxv_start_nxt = 1'b1;
        w_k_nxt         = '0;
        w_state_nxt     = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (mxv_done) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          w_tx_data_nxt   = res_data;
          w_tx_enable_nxt = 1'b1;
          w_seen_busy_nxt = 1'b0;
          w_state_nxt     = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        // Advance only on the falling edge of busy that follows our own request.
        if (tx_busy) begin
          w_seen_busy_nxt = 1'b1;
        end else if (r_seen_busy) begin
          if (r_k == r_mxv_n - 4'd1) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_k_nxt     = r_k + 4'd1;
            w_state_nxt = ST_READ;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_expired) begin
      w_frame_err_nxt = 1'b1;
      w_state_nxt     = ST_IDLE;
    end
  end

  assign ld_we     = r_ld_we;
  assign ld_sel    = r_ld_sel;
  assign ld_addr   = r_ld_addr;
  assign ld_data   = r_ld_data;
  assign mxv_n     = r_mxv_n;
  assign mxv_start = r_mxv_start;
  assign res_addr  = ADDR_W'(r_k);
  assign tx_data   = r_tx_data;
  assign tx_enable = r_tx_enable;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
